reaction_round_ctrl: RTL and testbench

- Sequential controller for one reaction-time round.
- On start it picks a pseudo-random 16-bit delay target and counts millisecond ticks until the count equals the target. It then lights the go stimulus and measures the time until the player presses the button.
- Produces the values and events that the 16-bit equality compare and score logic consume downstream. Handles false starts and timeouts.

---
 rtl/reaction_round_ctrl_if.sv | 24 ++
 rtl/reaction_round_ctrl.sv | 132 +++++++++++++
 tb/tb_reaction_round_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/reaction_round_ctrl_if.sv
// Handshake bundle between the reaction-round controller and its environment.
// The master drives start/button; the slave (controller) drives the status and results.
`timescale 1ns/1ps
interface reaction_round_ctrl_if;
  logic        start;
  logic        button;
  logic        go;
  logic        busy;
  logic        done;
  logic        false_start;
  logic        timeout;
  logic [15:0] react_ms;
  logic [15:0] target_ms;

  modport master (
    output start, button,
    input  go, busy, done, false_start, timeout, react_ms, target_ms
  );

  modport slave (
    input  start, button,
    output go, busy, done, false_start, timeout, react_ms, target_ms
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// One reaction-time round: random delay in ms ticks, light go, time the press.
// Flags false starts and timeouts; every output is a register.
`timescale 1ns/1ps
module reaction_round_ctrl #(
  parameter int          CLK_PER_TICK = 50000,
  parameter logic [15:0] MIN_DELAY    = 16'd500,
  parameter logic [15:0] DELAY_MASK   = 16'h07FF,
  parameter logic [15:0] MAX_REACT    = 16'd9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  reaction_round_ctrl_if.slave bus
);

  localparam int             PW        = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0]  LAST_TICK = PW'(CLK_PER_TICK - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_GO, S_RESULT} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_delay;
  logic          r_btn_q;
  logic          r_go;
  logic          r_busy;
  logic          r_done;
  logic          r_false_start;
  logic          r_timeout;
  logic [15:0]   r_react;
  logic [15:0]   r_target;

  logic          w_press;
  logic          w_tick;
  logic [15:0]   w_lfsr_next;
  logic [PW-1:0] w_presc_next;

  assign w_press      = bus.button & ~r_btn_q;
  assign w_tick       = (r_presc == LAST_TICK);
  assign w_presc_next = w_tick ? '0 : r_presc + PW'(1);
  // Galois right shift; an all-zero register would lock up, so it reloads the seed.
  assign w_lfsr_next  = (r_lfsr == 16'h0000) ? LFSR_SEED
                      : ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= LFSR_SEED;
      r_presc       <= '0;
      r_delay       <= '0;
      r_btn_q       <= 1'b0;
      r_go          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_react       <= '0;
      r_target      <= '0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_btn_q <= bus.button;
      r_done  <= 1'b0;
      r_presc <= w_presc_next;
      case (r_state)
        S_IDLE, S_RESULT: begin
          if (bus.start) begin
            r_state       <= S_ARM;
            r_busy        <= 1'b1;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
            r_react       <= '0;
            r_presc       <= '0;
          end
        end
        S_ARM: begin
          r_target <= MIN_DELAY + (r_lfsr & DELAY_MASK);
          r_delay  <= '0;
          r_presc  <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // A press outranks reaching the target in the same cycle.
          if (w_press) begin
            r_false_start <= 1'b1;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_presc       <= '0;
            r_state       <= S_RESULT;
          end else if (r_delay == r_target) begin
            r_go    <= 1'b1;
            r_react <= '0;
            r_presc <= '0;
            r_state <= S_GO;
          end else if (w_tick) begin
            r_delay <= r_delay + 16'd1;
          end
        end
        S_GO: begin
          if (w_press) begin
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_presc <= '0;
            r_state <= S_RESULT;
          end else if (r_react == MAX_REACT) begin
            r_timeout <= 1'b1;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_presc   <= '0;
            r_state   <= S_RESULT;
          end else if (w_tick) begin
            r_react <= r_react + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.go          = r_go;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.false_start = r_false_start;
  assign bus.timeout     = r_timeout;
  assign bus.react_ms    = r_react;
  assign bus.target_ms   = r_target;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: a fixed-delay instance for timing/flags and a
// random-delay instance whose targets are predicted by a reference LFSR model.
`timescale 1ns/1ps
module tb_reaction_round_ctrl;

  localparam int          CPT     = 4;
  localparam int          MIN_A   = 3;
  localparam int          MAX_R   = 10;
  localparam int          MIN_B   = 500;
  localparam logic [15:0] MASK_B  = 16'h07FF;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reaction_round_ctrl_if if_a ();
  reaction_round_ctrl_if if_b ();

  reaction_round_ctrl #(
    .CLK_PER_TICK(CPT), .MIN_DELAY(16'(MIN_A)), .DELAY_MASK(16'h0000),
    .MAX_REACT(16'(MAX_R)), .LFSR_SEED(SEED)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));

  reaction_round_ctrl #(
    .CLK_PER_TICK(CPT), .MIN_DELAY(16'(MIN_B)), .DELAY_MASK(MASK_B),
    .MAX_REACT(16'(MAX_R)), .LFSR_SEED(SEED)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));

  // Reference sequence of the random source for instance b.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst_b || m_lfsr == 16'h0000) m_lfsr <= SEED;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a round on a, verify the ARM cycle, then wait for go and check its latency.
  task automatic a_start_to_go();
    int k;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    k = 1;
    check("a_busy_arm", if_a.busy, 1);
    check("a_flags_clr", {if_a.false_start, if_a.timeout}, 0);
    check("a_react_clr", if_a.react_ms, 0);
    @(negedge clk);
    k = 2;
    check("a_target", if_a.target_ms, MIN_A);
    while (!if_a.go && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("a_go_latency", k, 3 + CPT * MIN_A);
  endtask

  // Called at the first sample with go high; presses n cycles later (n <= 40).
  task automatic a_press_after(input int n);
    int exp_react;
    if_a.button = 1'b0;
    repeat (n) @(negedge clk);
    check("a_go_held", if_a.go, 1);
    exp_react = (n / CPT > MAX_R) ? MAX_R : n / CPT;
    if_a.button = 1'b1;
    @(negedge clk);
    check("a_done_press", if_a.done, 1);
    check("a_go_off", if_a.go, 0);
    check("a_busy_off", if_a.busy, 0);
    check("a_flags_press", {if_a.false_start, if_a.timeout}, 0);
    check("a_react", if_a.react_ms, exp_react);
    @(negedge clk);
    check("a_done_1cyc", if_a.done, 0);
    check("a_react_held", if_a.react_ms, exp_react);
    if_a.button = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Start a round on b, predict the target from the model, then end it with a false start.
  task automatic b_round(input bit poke_start);
    logic [15:0] exp_t;
    int          gap;
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    exp_t = 16'(MIN_B) + (m_lfsr & MASK_B);
    @(negedge clk);
    check("b_target", if_b.target_ms, exp_t);
    check("b_range", (if_b.target_ms >= 16'd500 && if_b.target_ms <= 16'd2547), 1);
    check("b_lfsr_nz", (dut_b.r_lfsr != 16'h0000), 1);
    check("b_busy", if_b.busy, 1);
    gap = $urandom_range(1, 30);
    repeat (gap) @(negedge clk);
    if (poke_start) begin
      if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      repeat (3) @(negedge clk);
      check("b_start_ignored_tgt", if_b.target_ms, exp_t);
      check("b_start_ignored_busy", if_b.busy, 1);
    end
    if_b.button = 1'b1;
    @(negedge clk);
    check("b_false_start", if_b.false_start, 1);
    check("b_done", if_b.done, 1);
    check("b_go", if_b.go, 0);
    if_b.button = 1'b0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
  endtask

  initial begin
    int c;
    int gos;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.start = 1'b0; if_a.button = 1'b0;
    if_b.start = 1'b0; if_b.button = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_outs", {if_a.go, if_a.busy, if_a.done, if_a.false_start, if_a.timeout}, 0);
    check("rst_a_react", if_a.react_ms, 0);
    check("rst_a_target", if_a.target_ms, 0);
    check("rst_a_lfsr", dut_a.r_lfsr, SEED);
    check("rst_b_outs", {if_b.go, if_b.busy, if_b.done, if_b.false_start, if_b.timeout}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // Directed press 5 ticks after go, then the press coinciding with the timeout cycle.
    a_start_to_go();
    a_press_after(5 * CPT);
    a_start_to_go();
    a_press_after(MAX_R * CPT);

    // Randomized reaction times.
    for (int i = 0; i < 6; i++) begin
      a_start_to_go();
      a_press_after($urandom_range(0, MAX_R * CPT));
    end

    // Button held across start is not a press; release at go and press 9 cycles later.
    if_a.button = 1'b1;
    a_start_to_go();
    check("a_held_no_fs", if_a.false_start, 0);
    a_press_after(9);

    // False start one tick into WAIT.
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (5) @(negedge clk);
    if_a.button = 1'b1;
    @(negedge clk);
    check("a_fs_flag", if_a.false_start, 1);
    check("a_fs_done", if_a.done, 1);
    check("a_fs_busy", if_a.busy, 0);
    check("a_fs_react", if_a.react_ms, 0);
    if_a.button = 1'b0;
    gos = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.go) gos++;
    end
    check("a_fs_no_go", gos, 0);
    check("a_fs_sticky", if_a.false_start, 1);

    // Timeout with no press.
    a_start_to_go();
    c = 0;
    while (!if_a.done && c < 80) begin
      @(negedge clk);
      c++;
    end
    check("a_to_latency", c, MAX_R * CPT + 1);
    check("a_to_flag", if_a.timeout, 1);
    check("a_to_react", if_a.react_ms, MAX_R);
    check("a_to_go", if_a.go, 0);
    @(negedge clk);
    check("a_to_done_1cyc", if_a.done, 0);
    check("a_to_sticky", if_a.timeout, 1);

    // Reset in the middle of GO.
    a_start_to_go();
    repeat (6) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_go", if_a.go, 0);
    check("a_rst_busy", if_a.busy, 0);
    check("a_rst_react", if_a.react_ms, 0);
    check("a_rst_target", if_a.target_ms, 0);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    check("a_rst_stays_idle", {if_a.go, if_a.busy}, 0);

    // Random-delay rounds; one of them also pokes start during WAIT.
    for (int i = 0; i < 20; i++) b_round(i == 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
